// File: rtl/prod_accum_pkg.sv
// Shared types and defaults for the product accumulator slice.
package prod_accum_pkg;

   localparam int DEF_DEPTH   = 16;
   localparam int DEF_XW      = 16;
   localparam int DEF_SW      = 20;
   localparam int DEF_TIMEOUT = 1024;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'b0001,
      ST_KICK    = 4'b0010,
      ST_COLLECT = 4'b0100,
      ST_DONE    = 4'b1000
   } state_t;

   // CNT must be able to hold DEPTH itself, not just DEPTH-1.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/sat_add.sv
// Unsigned adder of an AW-bit accumulator and a BW-bit operand, clamping at 2^AW-1.
module sat_add #(
   parameter int AW = 20,
   parameter int BW = 16
) (
   input  logic [AW-1:0] a,
   input  logic [BW-1:0] b,
   output logic [AW-1:0] sum,
   output logic          ovf
);

   localparam int EW = ((AW > BW) ? AW : BW) + 1;

   logic [EW-1:0] full;

   always_comb begin
      full = EW'(a) + EW'(b);
      ovf  = |full[EW-1:AW];
      sum  = ovf ? '1 : full[AW-1:0];
   end

endmodule

// File: rtl/prod_accum.sv
// Kicks one multiply batch, accumulates DEPTH products (saturating sum and max),
// and holds the result for the host until acknowledged; a watchdog ends stalled batches.
module prod_accum
   import prod_accum_pkg::*;
#(
   parameter int DEPTH   = DEF_DEPTH,
   parameter int XW      = DEF_XW,
   parameter int SW      = DEF_SW,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          GO,
   output logic                          START,
   input  logic [XW-1:0]                 X,
   input  logic                          X_VALID,
   output logic [SW-1:0]                 SUM,
   output logic [XW-1:0]                 MAXV,
   output logic [cnt_width(DEPTH)-1:0]   CNT,
   output logic                          SUM_VALID,
   input  logic                          SUM_ACK,
   output logic                          BUSY,
   output logic                          OVF,
   output logic                          TMO,
   output logic                          ERR
);

   localparam int CW = cnt_width(DEPTH);
   localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   state_t        state;
   logic [WW-1:0] wdog;
   logic [SW-1:0] sum_next;
   logic          ovf_next;

   sat_add #(
      .AW (SW),
      .BW (XW)
   ) u_sat_add (
      .a   (SUM),
      .b   (X),
      .sum (sum_next),
      .ovf (ovf_next)
   );

   assign BUSY = (state != ST_IDLE);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= ST_IDLE;
         SUM       <= '0;
         MAXV      <= '0;
         CNT       <= '0;
         wdog      <= '0;
         START     <= 1'b0;
         SUM_VALID <= 1'b0;
         OVF       <= 1'b0;
         TMO       <= 1'b0;
         ERR       <= 1'b0;
      end else begin
         START <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (X_VALID) ERR <= 1'b1;
               if (GO) begin
                  state <= ST_KICK;
                  START <= 1'b1;
               end
            end
            ST_KICK: begin
               SUM   <= '0;
               MAXV  <= '0;
               CNT   <= '0;
               wdog  <= '0;
               OVF   <= 1'b0;
               TMO   <= 1'b0;
               // A stray beat during the kick re-flags the freshly cleared error.
               ERR   <= X_VALID;
               state <= ST_COLLECT;
            end
            ST_COLLECT: begin
               if (X_VALID) begin
                  SUM  <= sum_next;
                  CNT  <= CNT + CW'(1);
                  wdog <= '0;
                  if (ovf_next) OVF <= 1'b1;
                  if (X > MAXV) MAXV <= X;
                  if (CNT == CW'(DEPTH - 1)) begin
                     state     <= ST_DONE;
                     SUM_VALID <= 1'b1;
                  end
               end else if (wdog == WW'(TIMEOUT - 1)) begin
                  state     <= ST_DONE;
                  SUM_VALID <= 1'b1;
                  TMO       <= 1'b1;
               end else begin
                  wdog <= wdog + WW'(1);
               end
            end
            ST_DONE: begin
               if (X_VALID) ERR <= 1'b1;
               if (SUM_ACK) begin
                  state     <= ST_IDLE;
                  SUM_VALID <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prod_accum.sv
// Directed bench for prod_accum: a 20-bit-sum instance and a 16-bit saturating instance share stimulus.
module tb_prod_accum;

   logic        CLK = 1'b0;
   logic        RST;
   logic        GO;
   logic [15:0] X;
   logic        X_VALID;
   logic        SUM_ACK;

   logic        START, SUM_VALID, BUSY, OVF, TMO, ERR;
   logic [19:0] SUM;
   logic [15:0] MAXV;
   logic [4:0]  CNT;

   logic        start_b, sum_valid_b, busy_b, ovf_b, tmo_b, err_b;
   logic [15:0] sum_b;
   logic [15:0] maxv_b;
   logic [4:0]  cnt_b;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 CLK = ~CLK;

   prod_accum #(.DEPTH(16), .XW(16), .SW(20), .TIMEOUT(8)) dut (
      .CLK(CLK), .RST(RST), .GO(GO), .START(START), .X(X), .X_VALID(X_VALID),
      .SUM(SUM), .MAXV(MAXV), .CNT(CNT), .SUM_VALID(SUM_VALID), .SUM_ACK(SUM_ACK),
      .BUSY(BUSY), .OVF(OVF), .TMO(TMO), .ERR(ERR)
   );

   prod_accum #(.DEPTH(16), .XW(16), .SW(16), .TIMEOUT(8)) dut16 (
      .CLK(CLK), .RST(RST), .GO(GO), .START(start_b), .X(X), .X_VALID(X_VALID),
      .SUM(sum_b), .MAXV(maxv_b), .CNT(cnt_b), .SUM_VALID(sum_valid_b), .SUM_ACK(SUM_ACK),
      .BUSY(busy_b), .OVF(ovf_b), .TMO(tmo_b), .ERR(err_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // GO for one cycle, check the kick, then advance into COLLECT.
   task automatic kick(input string tag);
      GO = 1'b1;
      step();
      GO = 1'b0;
      check({tag, "_start"}, START, 1);
      check({tag, "_busy"}, BUSY, 1);
      step();
      check({tag, "_start_low"}, START, 0);
   endtask

   task automatic beat(input logic [15:0] v);
      X = v;
      X_VALID = 1'b1;
      step();
      X_VALID = 1'b0;
   endtask

   task automatic ack();
      SUM_ACK = 1'b1;
      step();
      SUM_ACK = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "bench time limit exceeded");
   end

   initial begin
      RST = 1'b0; GO = 1'b0; X = '0; X_VALID = 1'b0; SUM_ACK = 1'b0;
      #12;
      check("rst_sum", SUM, 0);
      check("rst_cnt", CNT, 0);
      check("rst_busy", BUSY, 0);
      check("rst_valid", SUM_VALID, 0);
      check("rst_err", ERR, 0);
      RST = 1'b1;
      step();

      // Test 1: X = 1..16
      kick("t1");
      for (int i = 1; i <= 16; i++) begin
         if (i == 16) check("t1_valid_before_last", SUM_VALID, 0);
         beat(16'(i));
      end
      check("t1_valid", SUM_VALID, 1);
      check("t1_sum", SUM, 136);
      check("t1_maxv", MAXV, 16);
      check("t1_cnt", CNT, 16);
      check("t1_ovf", OVF, 0);
      check("t1_tmo", TMO, 0);
      check("t1_err", ERR, 0);
      ack();
      check("t1_valid_clr", SUM_VALID, 0);
      check("t1_idle", BUSY, 0);
      check("t1_hold_sum", SUM, 136);

      // Test 2: 16 x FFFF, 20-bit vs 16-bit accumulator
      kick("t2");
      for (int i = 0; i < 16; i++) beat(16'hFFFF);
      check("t2_sum20", SUM, 32'h000F_FFF0);
      check("t2_ovf20", OVF, 0);
      check("t2_maxv", MAXV, 32'hFFFF);
      check("t2_sum16", sum_b, 32'hFFFF);
      check("t2_ovf16", ovf_b, 1);
      check("t2_valid16", sum_valid_b, 1);
      ack();

      // Test 3: 5 beats of 3, then watchdog expiry after 8 idle cycles
      kick("t3");
      check("t3_ovf_cleared", ovf_b, 0);
      for (int i = 0; i < 5; i++) beat(16'd3);
      for (int i = 0; i < 7; i++) step();
      check("t3_not_yet", SUM_VALID, 0);
      check("t3_still_busy", BUSY, 1);
      step();
      check("t3_valid", SUM_VALID, 1);
      check("t3_tmo", TMO, 1);
      check("t3_sum", SUM, 15);
      check("t3_cnt", CNT, 5);
      check("t3_maxv", MAXV, 3);
      ack();

      // Test 4: beat while IDLE sets ERR, result untouched; KICK clears ERR
      X = 16'd100; X_VALID = 1'b1;
      step();
      X_VALID = 1'b0;
      check("t4_err", ERR, 1);
      check("t4_sum", SUM, 15);
      check("t4_cnt", CNT, 5);
      GO = 1'b1;
      step();
      GO = 1'b0;
      check("t4_err_in_kick", ERR, 1);
      step();
      check("t4_err_cleared", ERR, 0);
      for (int i = 0; i < 16; i++) beat((i == 3) ? 16'd500 : 16'd10);
      check("t4_sum_mix", SUM, 650);
      check("t4_maxv_mix", MAXV, 500);
      check("t4_err_final", ERR, 0);
      ack();

      // Test 5: asynchronous reset after 7 beats
      kick("t5");
      for (int i = 0; i < 7; i++) beat(16'd9);
      check("t5_partial", SUM, 63);
      #3 RST = 1'b0;
      #1;
      check("t5_sum", SUM, 0);
      check("t5_maxv", MAXV, 0);
      check("t5_cnt", CNT, 0);
      check("t5_busy", BUSY, 0);
      check("t5_valid", SUM_VALID, 0);
      check("t5_flags", {START, OVF, TMO, ERR}, 0);
      #2 RST = 1'b1;
      step();
      kick("t5b");
      for (int i = 1; i <= 16; i++) beat(16'(i));
      check("t5b_sum", SUM, 136);
      check("t5b_cnt", CNT, 16);
      check("t5b_maxv", MAXV, 16);
      ack();

      // Test 6: DONE held 50 cycles with GO high, then ack and re-kick
      kick("t6");
      for (int i = 0; i < 16; i++) beat(16'd2);
      GO = 1'b1;
      for (int i = 0; i < 50; i++) begin
         check("t6_hold_valid", SUM_VALID, 1);
         check("t6_hold_sum", SUM, 32);
         check("t6_no_start", START, 0);
         step();
      end
      SUM_ACK = 1'b1;
      step();
      SUM_ACK = 1'b0;
      check("t6_valid_clr", SUM_VALID, 0);
      check("t6_no_start_idle", START, 0);
      step();
      check("t6_restart", START, 1);
      GO = 1'b0;
      step();
      check("t6_restart_low", START, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
